// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: latches a packed hex value on load and scans it
// across DIGITS digits with dead time, leading-zero suppression, blanking and blinking.
module seven_segment_scanner #(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD        = 2,
    parameter int BLINK_TICKS = 64,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     anodes
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic ST_DEAD = 1'b0;
    localparam logic ST_SHOW = 1'b1;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       bcnt;
    logic                phase;
    logic                tick;
    logic                state;

    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_blank;
    logic [DIGITS-1:0]   sh_blink;
    logic                sh_lz;

    logic [DIGITS-1:0]   supp;
    logic                zhi;
    logic [3:0]          nib;
    logic                dark;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   an_n;

    assign tick  = (cnt == CW'(CLK_DIV - 1));
    assign state = (cnt < CW'(DEAD)) ? ST_DEAD : ST_SHOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_val   <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
            sh_lz    <= 1'b0;
        end else if (load) begin
            sh_val   <= value;
            sh_blank <= blank_mask;
            sh_blink <= blink_mask;
            sh_lz    <= lz_en;
        end
    end

    // Walk down from the top digit; a digit is suppressed while everything above it is zero.
    always_comb begin
        supp = '0;
        zhi  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zhi     = zhi & (sh_val[4*i +: 4] == 4'h0);
            supp[i] = sh_lz & zhi;
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;  default: decode = 7'h71;
        endcase
    endfunction

    assign nib  = sh_val[{idx, 2'b00} +: 4];
    assign dark = sh_blank[idx] | (sh_blink[idx] & ~phase) | supp[idx];

    always_comb begin
        seg_n = '0;
        an_n  = '0;
        if (state == ST_SHOW && !dark) begin
            seg_n = decode(nib);
            an_n  = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segments <= {7{ACTIVE_LOW}};
            anodes   <= {DIGITS{ACTIVE_LOW}};
        end else begin
            segments <= seg_n ^ {7{ACTIVE_LOW}};
            anodes   <= an_n ^ {DIGITS{ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: arithmetic model checked every cycle, plus
// hand-computed literal checks on the directed scenarios.
module tb_seven_segment_scanner;
    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;
    localparam int BT      = 4;

    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  segments;
    logic [3:0]  anodes;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD), .BLINK_TICKS(BT), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
        .segments(segments), .anodes(anodes)
    );

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // t = cycles since the last reset edge; slot/phase/digit all follow from it.
    function automatic logic [10:0] model_out(input int t, input logic [15:0] v,
                                              input logic [3:0] bl, input logic [3:0] bk,
                                              input logic lz);
        int          slot = t / CLK_DIV;
        int          d = slot % DIGITS;
        bit          visible = ((slot / BT) % 2) == 0;
        logic [15:0] hi = v >> (4 * d);
        logic [6:0]  seg = 7'h00;
        logic [3:0]  an = 4'h0;
        if ((t % CLK_DIV) >= DEAD && !bl[d] && !(bk[d] && !visible) && !(lz && d != 0 && hi == 16'h0)) begin
            seg = GLYPH[hi[3:0]];
            an  = 4'(1 << d);
        end
        return {~seg, ~an};
    endfunction

    int          t = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_blink = '0;
    logic        m_lz = 1'b0;
    logic [10:0] exp_out = '0;
    bit          exp_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_out <= {7'h7F, 4'hF};
            t       <= 0;
            m_val   <= '0;
            m_blank <= '0;
            m_blink <= '0;
            m_lz    <= 1'b0;
        end else begin
            exp_out <= model_out(t, m_val, m_blank, m_blink, m_lz);
            t       <= t + 1;
            if (load) begin
                m_val   <= value;
                m_blank <= blank_mask;
                m_blink <= blink_mask;
                m_lz    <= lz_en;
            end
        end
        exp_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_seg", {9'h0, segments}, {9'h0, exp_out[10:4]});
            check("model_an", {12'h0, anodes}, {12'h0, exp_out[3:0]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [6:0] s, input logic [3:0] a);
        check({nm, "_seg"}, {9'h0, segments}, {9'h0, s});
        check({nm, "_an"}, {12'h0, anodes}, {12'h0, a});
    endtask

    // Reset one cycle, then load on the first post-reset edge; returns after that edge.
    task automatic restart(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] bk, input logic lz);
        reset = 1'b1;
        step(1);
        reset      = 1'b0;
        load       = 1'b1;
        value      = v;
        blank_mask = bl;
        blink_mask = bk;
        lz_en      = lz;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        // Reset held 3 cycles, release with load low
        step(1); lit("rst0", 7'h7F, 4'hF);
        step(1); lit("rst1", 7'h7F, 4'hF);
        step(1); lit("rst2", 7'h7F, 4'hF);
        reset = 1'b0;
        step(1); lit("rel_dead0", 7'h7F, 4'hF);
        step(1); lit("rel_dead1", 7'h7F, 4'hF);
        step(1); lit("rel_d0", 7'h40, 4'b1110);
        step(6); lit("rel_slot1_dead", 7'h7F, 4'hF);
        step(2); lit("rel_d1", 7'h40, 4'b1101);

        // Full scan of 12AF
        restart(16'h12AF, 4'h0, 4'h0, 1'b0);
        step(2);  lit("scan_d0", 7'h0E, 4'b1110);
        step(8);  lit("scan_d1", 7'h08, 4'b1101);
        step(8);  lit("scan_d2", 7'h24, 4'b1011);
        step(8);  lit("scan_d3", 7'h79, 4'b0111);
        step(6);  lit("scan_wrap_dead", 7'h7F, 4'hF);
        step(2);  lit("scan_wrap_d0", 7'h0E, 4'b1110);

        // Leading-zero suppression
        restart(16'h0040, 4'h0, 4'h0, 1'b1);
        step(2);  lit("lz_d0", 7'h40, 4'b1110);
        step(8);  lit("lz_d1", 7'h19, 4'b1101);
        step(8);  lit("lz_d2", 7'h7F, 4'hF);
        step(8);  lit("lz_d3", 7'h7F, 4'hF);
        load = 1'b1; value = 16'h0000;
        step(1);
        load = 1'b0;
        step(15); lit("lz0_d1", 7'h7F, 4'hF);
        step(24); lit("lz0_d0", 7'h40, 4'b1110);

        // Blink on digit 0
        restart(16'h12AF, 4'h0, 4'b0001, 1'b0);
        step(2);  lit("blink_on0", 7'h0E, 4'b1110);
        step(32); lit("blink_off", 7'h7F, 4'hF);
        step(32); lit("blink_on1", 7'h0E, 4'b1110);
        step(32); lit("blink_off1", 7'h7F, 4'hF);

        // Blink plus blank on digit 3
        restart(16'h12AF, 4'b1000, 4'b0001, 1'b0);
        step(2);  lit("bb_d0", 7'h0E, 4'b1110);
        step(16); lit("bb_d2", 7'h24, 4'b1011);
        step(8);  lit("bb_d3", 7'h7F, 4'hF);
        step(32); lit("bb_d3_again", 7'h7F, 4'hF);

        // Load at cnt=4, then reset at cnt=5 of the next slot
        restart(16'h12AF, 4'h0, 4'h0, 1'b0);
        step(3);
        load = 1'b1; value = 16'h1230;
        step(1);  lit("ld_edge_old", 7'h0E, 4'b1110);
        load = 1'b0;
        step(1);  lit("ld_new", 7'h40, 4'b1110);
        step(7);  lit("ld_d1", 7'h30, 4'b1101);
        reset = 1'b1;
        step(1);  lit("mid_reset", 7'h7F, 4'hF);
        reset = 1'b0;
        step(1);  lit("mid_rel_dead", 7'h7F, 4'hF);
        step(2);  lit("mid_rel_d0", 7'h40, 4'b1110);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
